// File: rtl/aurora_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one Aurora 8b/10b TX AXI-stream
// interface between two frame sources. Once a source is granted, it keeps the
// link until its TLAST beat is transferred. If the channel drops mid-frame,
// the rest of that frame is drained from the source and counted as aborted.
// GRANT stays one-hot on the owning source through GRANTED and DRAIN.
module aurora_tx_arbiter #(
  parameter int FRAME_CNT_W = 16,
  parameter int ABORT_CNT_W = 8
) (
  input  logic                   IO_CLK,
  input  logic                   RESET_N,
  input  logic                   CHANNEL_UP,
  input  logic [0:31]            S0_TDATA,
  input  logic [0:3]             S0_TKEEP,
  input  logic                   S0_TVALID,
  input  logic                   S0_TLAST,
  output logic                   S0_TREADY,
  input  logic [0:31]            S1_TDATA,
  input  logic [0:3]             S1_TKEEP,
  input  logic                   S1_TVALID,
  input  logic                   S1_TLAST,
  output logic                   S1_TREADY,
  output logic [0:31]            M_TDATA,
  output logic [0:3]             M_TKEEP,
  output logic                   M_TVALID,
  output logic                   M_TLAST,
  input  logic                   M_TREADY,
  output logic [1:0]             GRANT,
  output logic                   BUSY,
  output logic [FRAME_CNT_W-1:0] FRAME_CNT_0,
  output logic [FRAME_CNT_W-1:0] FRAME_CNT_1,
  output logic [ABORT_CNT_W-1:0] ABORT_CNT
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANTED, ST_DRAIN} state_t;

  state_t     state, state_nxt;
  logic       g, g_nxt;       // granted source index
  logic       rr, rr_nxt;     // preferred source for the next arbitration
  logic       frame_done;     // granted frame fully forwarded this cycle
  logic       frame_abort;    // drained frame ended this cycle
  logic       sel_tready;     // ready towards the granted source

  logic [0:31] sel_tdata;
  logic [0:3]  sel_tkeep;
  logic        sel_tvalid;
  logic        sel_tlast;

  // Select the fields of the currently granted source.
  always_comb begin
    if (g) begin
      sel_tdata  = S1_TDATA;
      sel_tkeep  = S1_TKEEP;
      sel_tvalid = S1_TVALID;
      sel_tlast  = S1_TLAST;
    end else begin
      sel_tdata  = S0_TDATA;
      sel_tkeep  = S0_TKEEP;
      sel_tvalid = S0_TVALID;
      sel_tlast  = S0_TLAST;
    end
  end

  // Next-state logic and zero-latency passthrough.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    g_nxt       = g;
    rr_nxt      = rr;
    frame_done  = 1'b0;
    frame_abort = 1'b0;
    sel_tready  = 1'b0;
    M_TDATA     = '0;
    M_TKEEP     = '0;
    M_TVALID    = 1'b0;
    M_TLAST     = 1'b0;
    GRANT       = 2'b00;
    BUSY        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (CHANNEL_UP && (S0_TVALID || S1_TVALID)) begin
          g_nxt     = (rr ? S1_TVALID : S0_TVALID) ? rr : ~rr;
          state_nxt = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        BUSY       = 1'b1;
        GRANT      = g ? 2'b10 : 2'b01;
        M_TDATA    = sel_tdata;
        M_TKEEP    = sel_tkeep;
        M_TLAST    = sel_tlast;
        M_TVALID   = sel_tvalid & CHANNEL_UP;
        sel_tready = M_TREADY & CHANNEL_UP;
        if (!CHANNEL_UP) begin
          // The beat on offer is not transferred; the frame is abandoned.
          state_nxt = ST_DRAIN;
        end else if (sel_tvalid && M_TREADY && sel_tlast) begin
          state_nxt  = ST_IDLE;
          frame_done = 1'b1;
          rr_nxt     = ~g;
        end
      end
      ST_DRAIN: begin
        // Swallow the rest of the frame regardless of the channel state.
        BUSY       = 1'b1;
        GRANT      = g ? 2'b10 : 2'b01;
        sel_tready = 1'b1;
        if (sel_tvalid && sel_tlast) begin
          state_nxt   = ST_IDLE;
          frame_abort = 1'b1;
          rr_nxt      = ~g;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign S0_TREADY = sel_tready & ~g;
  assign S1_TREADY = sel_tready &  g;

  // State, grant index and round-robin pointer.
  always_ff @(posedge IO_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      g     <= 1'b0;
      rr    <= 1'b0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      g     <= g_nxt;
      rr    <= rr_nxt;
    end
  end

  // Completed-frame counters wrap; the abort counter saturates.
  always_ff @(posedge IO_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FRAME_CNT_0 <= '0;
      FRAME_CNT_1 <= '0;
      ABORT_CNT   <= '0;
    end else begin
      if (frame_done && !g) FRAME_CNT_0 <= FRAME_CNT_0 + FRAME_CNT_W'(1);
      if (frame_done &&  g) FRAME_CNT_1 <= FRAME_CNT_1 + FRAME_CNT_W'(1);
      if (frame_abort && (ABORT_CNT != '1)) ABORT_CNT <= ABORT_CNT + ABORT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Scoreboard bench for aurora_tx_arbiter. A frame-level model decides the
// order in which whole frames must leave the arbiter (round-robin among the
// sources that still have frames queued) and pushes the expected beats; a
// monitor pops and compares every beat transferred on the M side.
module tb_aurora_tx_arbiter;

  localparam int FW = 16;
  localparam int AW = 8;

  typedef struct packed {
    logic [1:0]  grant;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic          io_clk = 1'b0;
  logic          reset_n;
  logic          channel_up;
  logic [0:31]   s_tdata  [2];
  logic [0:3]    s_tkeep  [2];
  logic          s_tvalid [2];
  logic          s_tlast  [2];
  logic          s0_tready, s1_tready;
  logic [0:31]   m_tdata;
  logic [0:3]    m_tkeep;
  logic          m_tvalid, m_tlast, m_tready;
  logic [1:0]    grant;
  logic          busy;
  logic [FW-1:0] frame_cnt_0, frame_cnt_1;
  logic [AW-1:0] abort_cnt;

  aurora_tx_arbiter #(.FRAME_CNT_W(FW), .ABORT_CNT_W(AW)) dut (
    .IO_CLK(io_clk), .RESET_N(reset_n), .CHANNEL_UP(channel_up),
    .S0_TDATA(s_tdata[0]), .S0_TKEEP(s_tkeep[0]), .S0_TVALID(s_tvalid[0]),
    .S0_TLAST(s_tlast[0]), .S0_TREADY(s0_tready),
    .S1_TDATA(s_tdata[1]), .S1_TKEEP(s_tkeep[1]), .S1_TVALID(s_tvalid[1]),
    .S1_TLAST(s_tlast[1]), .S1_TREADY(s1_tready),
    .M_TDATA(m_tdata), .M_TKEEP(m_tkeep), .M_TVALID(m_tvalid), .M_TLAST(m_tlast),
    .M_TREADY(m_tready), .GRANT(grant), .BUSY(busy),
    .FRAME_CNT_0(frame_cnt_0), .FRAME_CNT_1(frame_cnt_1), .ABORT_CNT(abort_cnt)
  );

  always #5 io_clk = ~io_clk;

  int       n_tests = 0;
  int       n_fail  = 0;
  int       cyc     = 0;
  beat_t    exp_q [$];
  beat_t    drv_q [2][$];
  bit       drv_busy [2];
  bit       sb_en = 1'b1;
  bit       gap_en = 1'b0;
  int       last_end_cyc = -1;
  int       ready_mode = 0;     // 0 hold, 1 random, 2 toggle

  // Frame-level reference model state.
  int            rr_model = 0;
  logic [FW-1:0] fc_model [2];
  logic [AW-1:0] abort_model;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 1) ? s1_tready : s0_tready;
  endfunction

  function automatic logic [1:0] onehot(input int k);
    return (k == 1) ? 2'b10 : 2'b01;
  endfunction

  initial forever begin
    @(posedge io_clk);
    cyc++;
  end

  // M_TREADY pattern generator.
  initial forever begin
    @(posedge io_clk);
    #1;
    if (ready_mode == 1) m_tready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2) m_tready = ~m_tready;
  end

  // Monitor: every M-side transfer must be the next expected beat.
  initial begin
    bit prev_last = 1'b1;
    forever begin
      @(negedge io_clk);
      if (sb_en && m_tvalid && m_tready) begin
        beat_t act_b, exp_b;
        act_b = {grant, 32'(m_tdata), 4'(m_tkeep), m_tlast};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no transfer (cycle %0d)", act_b, cyc);
        end else begin
          exp_b = exp_q.pop_front();
          check("m_beat", 64'(act_b), 64'(exp_b));
          if (gap_en && prev_last && last_end_cyc >= 0)
            check("frame_bubble", 64'(cyc - last_end_cyc), 64'd2);
          if (exp_b.last) last_end_cyc = cyc;
          prev_last = exp_b.last;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Present the queued beats of source k; optional idle gaps inside frames.
  task automatic run_driver(input int k, input bit gaps);
    bit first = 1'b1;
    drv_busy[k] = 1'b1;
    while (drv_q[k].size() > 0) begin
      beat_t b;
      int    t;
      b = drv_q[k].pop_front();
      if (gaps && !first && $urandom_range(0, 3) == 0) begin
        s_tvalid[k] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge io_clk);
        #1;
      end
      s_tdata[k]  = b.data;
      s_tkeep[k]  = b.keep;
      s_tlast[k]  = b.last;
      s_tvalid[k] = 1'b1;
      t = 0;
      forever begin
        @(negedge io_clk);
        if (rdy(k)) break;
        t++;
        if (t > 2000) break;
      end
      if (t > 2000) begin
        check("driver_timeout", 64'(k), 64'hff);
        drv_q[k].delete();
      end
      @(posedge io_clk);
      #1;
      first = b.last;
    end
    s_tvalid[k] = 1'b0;
    s_tlast[k]  = 1'b0;
    drv_busy[k] = 1'b0;
  endtask

  // Queue n0/n1 frames; the order they must leave in follows round-robin
  // among sources that still have frames waiting.
  task automatic plan(input int n0, input int n1, input int lmin, input int lmax);
    int rem [2];
    rem[0] = n0;
    rem[1] = n1;
    while (rem[0] + rem[1] > 0) begin
      int src, len;
      src = (rem[rr_model] > 0) ? rr_model : 1 - rr_model;
      len = $urandom_range(lmin, lmax);
      for (int i = 0; i < len; i++) begin
        beat_t b;
        b.grant = onehot(src);
        b.data  = $urandom;
        b.keep  = 4'($urandom_range(1, 15));
        b.last  = (i == len - 1);
        drv_q[src].push_back(b);
        exp_q.push_back(b);
      end
      rem[src]--;
      fc_model[src] = fc_model[src] + 1'b1;
      rr_model = 1 - src;
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_outs"},
          64'({s0_tready, s1_tready, m_tvalid, m_tlast, m_tkeep, m_tdata, grant, busy}), 64'd0);
    check({name, "_cnts"}, 64'({frame_cnt_0, frame_cnt_1, abort_cnt}), 64'd0);
  endtask

  task automatic check_counters(input string name);
    check({name, "_fc0"}, 64'(frame_cnt_0), 64'(fc_model[0]));
    check({name, "_fc1"}, 64'(frame_cnt_1), 64'(fc_model[1]));
    check({name, "_abort"}, 64'(abort_cnt), 64'(abort_model));
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    beat_t b;
    reset_n    = 1'b0;
    channel_up = 1'b0;
    m_tready   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_tdata[k] = '0; s_tkeep[k] = '0; s_tvalid[k] = 1'b0; s_tlast[k] = 1'b0;
      fc_model[k] = '0;
    end
    abort_model = '0;

    // Reset state.
    repeat (3) @(posedge io_clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // Two-beat S0 frame.
    channel_up = 1'b1;
    m_tready   = 1'b1;
    b = {2'b01, 32'hcafebabe, 4'hf, 1'b0};
    drv_q[0].push_back(b); exp_q.push_back(b);
    b = {2'b01, 32'hdeadbeef, 4'hf, 1'b1};
    drv_q[0].push_back(b); exp_q.push_back(b);
    fc_model[0] = fc_model[0] + 1'b1;
    rr_model = 1;
    run_driver(0, 1'b0);
    @(negedge io_clk);
    check("t1_idle_after", 64'({busy, grant}), 64'd0);
    check_counters("t1");
    @(posedge io_clk);
    #1;

    // Both sources offering 3-beat frames back to back.
    gap_en = 1'b1;
    last_end_cyc = -1;
    plan(2, 2, 3, 3);
    fork
      run_driver(0, 1'b0);
      run_driver(1, 1'b0);
    join
    gap_en = 1'b0;
    check_counters("t2");

    // M_TREADY toggling during an S1 frame.
    plan(0, 1, 4, 4);
    ready_mode = 2;
    fork
      run_driver(1, 1'b0);
      begin
        int acc = 0;
        forever begin
          @(negedge io_clk);
          if (!drv_busy[1]) break;
          check("t3_s1_ready_without_m", 64'(s1_tready & ~m_tready), 64'd0);
          check("t3_s0_ready", 64'(s0_tready), 64'd0);
          if (s1_tready) acc++;
        end
        check("t3_accept_count", 64'(acc), 64'd4);
      end
    join
    ready_mode = 0;
    m_tready   = 1'b1;
    check_counters("t3");

    // Channel drop on beat 2 of a 5-beat S0 frame; S1 waits behind it.
    for (int i = 0; i < 5; i++) begin
      b.grant = 2'b01; b.data = $urandom; b.keep = 4'hf; b.last = (i == 4);
      drv_q[0].push_back(b);
      if (i == 0) exp_q.push_back(b);
    end
    abort_model = abort_model + 1'b1;
    rr_model = 1;
    plan(0, 1, 2, 2);
    fork
      run_driver(0, 1'b0);
      run_driver(1, 1'b0);
      begin
        int t = 0;
        do begin
          @(negedge io_clk);
          t++;
        end while (!(m_tvalid && m_tready) && t < 50);
        check("t4_first_beat_seen", 64'(t < 50), 64'd1);
        @(posedge io_clk);
        #1;
        channel_up = 1'b0;
        @(negedge io_clk);
        check("t4_drop_cycle", 64'({m_tvalid, s0_tready, s1_tready}), 64'b000);
        for (int i = 0; i < 4; i++) begin
          @(negedge io_clk);
          check("t4_drain", 64'({m_tvalid, s0_tready, s1_tready}), 64'b010);
          if (i == 1) begin
            @(posedge io_clk);
            #1;
            channel_up = 1'b1;
          end
        end
      end
    join
    check_counters("t4");

    // Channel down with both sources valid, then channel up.
    channel_up = 1'b0;
    plan(1, 1, 1, 1);
    fork
      run_driver(0, 1'b0);
      run_driver(1, 1'b0);
      begin
        repeat (3) begin
          @(negedge io_clk);
          check("t5_no_grant", 64'({grant, s0_tready, s1_tready}), 64'd0);
        end
        @(posedge io_clk);
        #1;
        channel_up = 1'b1;
        @(negedge io_clk);
        check("t5_grant_not_yet", 64'(grant), 64'b00);
        @(negedge io_clk);
        check("t5_grant_s0", 64'(grant), 64'b01);
      end
    join
    check_counters("t5");

    // 260 aborted single-beat frames: counter saturates.
    m_tready = 1'b0;
    for (int i = 0; i < 260; i++) begin
      b = {2'b01, 32'(i), 4'hf, 1'b1};
      drv_q[0].push_back(b);
      fork
        run_driver(0, 1'b0);
        begin
          channel_up = 1'b1;
          @(posedge io_clk);
          #1;
          channel_up = 1'b0;
        end
      join
      if (abort_model != '1) abort_model = abort_model + 1'b1;
      rr_model = 1;
      if (i == 254) check("t6_abort_at_255", 64'(abort_cnt), 64'd255);
    end
    channel_up = 1'b1;
    m_tready   = 1'b1;
    check_counters("t6");

    // Random frames, random gaps, random M_TREADY.
    ready_mode = 1;
    plan(6, 5, 1, 6);
    fork
      run_driver(0, 1'b1);
      run_driver(1, 1'b1);
    join
    ready_mode = 0;
    m_tready   = 1'b1;
    check_counters("t7");

    // Reset asserted mid-frame.
    sb_en = 1'b0;
    s_tdata[0] = 32'h12345678; s_tkeep[0] = 4'hf; s_tlast[0] = 1'b0; s_tvalid[0] = 1'b1;
    repeat (3) @(posedge io_clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t8_reset");
    s_tvalid[0] = 1'b0;
    @(posedge io_clk);
    #1;
    reset_n = 1'b1;
    sb_en = 1'b1;
    fc_model[0] = '0; fc_model[1] = '0; abort_model = '0; rr_model = 0;
    plan(1, 1, 2, 2);
    fork
      run_driver(0, 1'b0);
      run_driver(1, 1'b0);
    join
    check_counters("t8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aurora_tx_arbiter.md
# aurora_tx_arbiter

Frame-atomic round-robin arbiter that shares one Aurora 8b/10b TX AXI-stream user interface between two requesters. It sits between two local frame sources and the Aurora core's TX_DATA/TX_TVALID/TX_TREADY/TX_TKEEP/TX_TLAST, in the IO_CLK domain. Frames are forwarded only while CHANNEL_UP is high. A frame interrupted by channel loss is drained from its source and counted as aborted.

## Interface
- FRAME_CNT_W, 16, width of the per-source completed-frame counters (wrap-around)
- ABORT_CNT_W, 8, width of the aborted-frame counter (saturating)

- IO_CLK  in  1  user clock; all logic is on its rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CHANNEL_UP  in  1  Aurora channel status, synchronous to IO_CLK
- S0_TDATA  in  [0:31]  source 0 data, byte 0 on bits [0:7]
- S0_TKEEP  in  [0:3]  source 0 byte enables
- S0_TVALID, S0_TLAST  in  1 each  source 0 valid / end of frame
- S0_TREADY  out  1  source 0 ready
- S1_TDATA, S1_TKEEP, S1_TVALID, S1_TLAST, S1_TREADY  same as source 0
- M_TDATA  out  [0:31]  to the Aurora TX_DATA
- M_TKEEP  out  [0:3]  to TX_TKEEP
- M_TVALID, M_TLAST  out  1 each  to TX_TVALID / TX_TLAST
- M_TREADY  in  1  from TX_TREADY
- GRANT  out  [1:0]  one-hot current owner; bit 0 = source 0
- BUSY  out  1  high in GRANTED or DRAIN
- FRAME_CNT_0, FRAME_CNT_1  out  FRAME_CNT_W  frames fully forwarded per source
- ABORT_CNT  out  ABORT_CNT_W  frames aborted by channel loss

## Operation
- State machine: IDLE, GRANTED, DRAIN. Registered state g holds the granted index. Registered round-robin pointer rr holds the preferred source.
- IDLE: all S_TREADY = 0, M_TVALID = 0, GRANT = 0.
  - If CHANNEL_UP = 1 and any S_TVALID = 1, grant source rr if it is valid, else the other source. Enter GRANTED.
  - Otherwise stay in IDLE.
- GRANTED, combinational passthrough from source g:
  - M_TDATA/M_TKEEP/M_TLAST = Sg fields.
  - M_TVALID = Sg_TVALID & CHANNEL_UP.
  - Sg_TREADY = M_TREADY & CHANNEL_UP.
  - The non-granted S_TREADY = 0.
- A transfer is a cycle with M_TVALID & M_TREADY.
- Transfer with M_TLAST = 1: go to IDLE, increment FRAME_CNT_g (wraps), set rr = 1 - g.
- CHANNEL_UP = 0 in GRANTED: no transfer that cycle; go to DRAIN.
- DRAIN:
  - M_TVALID = 0.
  - Sg_TREADY = 1; the other S_TREADY = 0.
  - Accepted beats are discarded.
  - On an accepted beat with Sg_TLAST = 1: go to IDLE, increment ABORT_CNT (saturate at all-ones), set rr = 1 - g.
  - FRAME_CNT is unchanged.
- DRAIN ignores CHANNEL_UP; the channel returning never resumes the frame.
- When not GRANTED, M_TDATA = 0, M_TKEEP = 0, M_TLAST = 0.
- Reset (RESET_N low, asynchronous): state IDLE, rr = 0, g = 0, all counters 0.
  - All outputs 0: S_TREADY, M_*, GRANT, BUSY, counters.
  - Reset asserted mid-frame abandons the frame without counting it. The source must resynchronise itself.

## Timing
- Arbitration latency: source valid in IDLE at edge n; GRANT and the first possible transfer at cycle n+1.
- Passthrough in GRANTED is zero-latency. M_TREADY reaches Sg_TREADY combinationally; there is no internal buffering.
- After each frame end there is exactly one IDLE cycle, so back-to-back frames cost 1 bubble.
- Simultaneous requests in IDLE: rr wins. After reset, source 0 wins.
- A single-beat frame (TLAST on the first beat) is legal: GRANTED lasts 1 cycle when M_TREADY = 1.
- CHANNEL_UP falling in the same cycle as a TLAST beat: the beat is not transferred. DRAIN accepts it next cycle, returns to IDLE and counts an abort.
- Sources must hold TVALID/fields stable until accepted (AXI rule). The arbiter does not check this.

## Test plan
- Reset then CHANNEL_UP = 1, S0 sends 0xcafebabe, then 0xdeadbeef with TLAST, TKEEP = 4'b1111, M_TREADY = 1 -> M outputs both words in order; GRANT = 2'b01 for 2 cycles; FRAME_CNT_0 = 1; then IDLE.
- Both sources continuously offer 3-beat frames -> grants alternate S0, S1, S0, S1; 1 idle cycle between frames; after 4 frames FRAME_CNT_0 = FRAME_CNT_1 = 2.
- M_TREADY toggles 1/0 during an S1 frame -> S1_TREADY mirrors M_TREADY; no beat is lost or duplicated; S0_TREADY stays 0.
- CHANNEL_UP drops on beat 2 of a 5-beat S0 frame -> M_TVALID = 0 from that cycle; S0_TREADY = 1 until S0 TLAST; ABORT_CNT = 1; FRAME_CNT_0 unchanged; the next grant goes to S1.
- CHANNEL_UP = 0 with both sources valid -> no grant, all ready = 0. On CHANNEL_UP = 1 -> source 0 granted 1 cycle later.
- Force 260 aborts -> ABORT_CNT saturates at 255.
- Assert RESET_N mid-frame -> all outputs 0 immediately; rr = 0 after release.
